// File: rtl/multicycle_mem_adapter_if.sv
// Signal bundle between the multicycle control path and the word-wide memory bus.
// The adapter uses the slave view; the control path / bus model uses the master view.
interface multicycle_mem_adapter_if;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [2:0]  data_format;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        mem_fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport slave (
    input  mem_read_enable, mem_write_enable, data_format, address, write_data,
    output read_data, mem_ready, mem_fault,
    output bus_req, bus_we, bus_addr, bus_byte_enable, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport master (
    output mem_read_enable, mem_write_enable, data_format, address, write_data,
    input  read_data, mem_ready, mem_fault,
    input  bus_req, bus_we, bus_addr, bus_byte_enable, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/multicycle_mem_adapter.sv
// Turns RISC-V byte/half/word load-store requests into single word-bus transactions
// with lane steering, alignment checking, ack timeout and a one-cycle completion pulse.
module multicycle_mem_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  multicycle_mem_adapter_if.slave       mif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic [2:0]  r_fmt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [7:0]  r_wait;
  logic        r_fault;
  logic [31:0] r_read_data;

  logic        w_req;
  logic        w_fault_in;
  logic [3:0]  w_be_in;
  logic [31:0] w_wdata_in;
  logic        w_ack;
  logic        w_timeout;
  logic [31:0] w_shift;
  logic [31:0] w_load;

  assign w_req     = mif.mem_read_enable | mif.mem_write_enable;
  assign w_ack     = (r_state == S_BUSY) && mif.bus_ack;
  assign w_timeout = (r_state == S_BUSY) && !mif.bus_ack && (r_wait == LP_WAIT_LAST);

  // Request decode: alignment/format check, lane enables and replicated store data.
  always_comb begin
    w_fault_in = 1'b1;
    w_be_in    = 4'b0000;
    w_wdata_in = mif.write_data;
    case (mif.data_format)
      3'b000, 3'b100: begin
        w_fault_in = 1'b0;
        w_be_in    = 4'b0001 << mif.address[1:0];
        w_wdata_in = {4{mif.write_data[7:0]}};
      end
      3'b001, 3'b101: begin
        w_fault_in = mif.address[0];
        w_be_in    = 4'b0011 << mif.address[1:0];
        w_wdata_in = {2{mif.write_data[15:0]}};
      end
      3'b010: begin
        w_fault_in = (mif.address[1:0] != 2'b00);
        w_be_in    = 4'b1111;
      end
      default: begin
        w_fault_in = 1'b1;
        w_be_in    = 4'b0000;
      end
    endcase
  end

  // Selected lane moved to bit 0; halves are aligned so the shift is 0 or 16.
  assign w_shift = mif.bus_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load = w_shift;
    case (r_fmt)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b101:  w_load = {16'd0, w_shift[15:0]};
      default: w_load = w_shift;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_state_next = w_fault_in ? S_DONE : S_BUSY;
      S_BUSY: if (w_ack || w_timeout) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_fmt       <= 3'b000;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'b0000;
      r_wait      <= 8'd0;
      r_fault     <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_we    <= mif.mem_write_enable;
            r_fmt   <= mif.data_format;
            r_addr  <= mif.address;
            r_wdata <= w_wdata_in;
            r_be    <= w_be_in;
            r_wait  <= 8'd0;
            r_fault <= w_fault_in;
            if (w_fault_in) r_read_data <= 32'd0;
          end
        end
        S_BUSY: begin
          // An ack in the last permitted cycle still completes normally.
          if (mif.bus_ack) begin
            r_fault <= 1'b0;
            if (!r_we) r_read_data <= w_load;
          end else begin
            r_wait <= r_wait + 8'd1;
            if (w_timeout) begin
              r_fault     <= 1'b1;
              r_read_data <= 32'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mif.bus_req         = (r_state == S_BUSY);
  assign mif.bus_we          = r_we;
  assign mif.bus_addr        = {r_addr[31:2], 2'b00};
  assign mif.bus_byte_enable = r_be;
  assign mif.bus_wdata       = r_wdata;
  assign mif.mem_ready       = (r_state == S_DONE);
  assign mif.mem_fault       = (r_state == S_DONE) && r_fault;
  assign mif.read_data       = r_read_data;

endmodule

// File: doc/multicycle_mem_adapter.md
MULTICYCLE_MEM_ADAPTER -- requirements
Module: multicycle_mem_adapter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus_ack wait limit in cycles, legal range 1..255.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port mem_read_enable, input, 1 bit: load or fetch request from the multicycle control path.
REQ-005 SHALL have port mem_write_enable, input, 1 bit: store request.
REQ-006 SHALL have port data_format, input, 3 bits: RISC-V funct3 access format (fetch uses 3'b010).
REQ-007 SHALL have port address, input, 32 bits: byte address.
REQ-008 SHALL have port write_data, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port read_data, output, 32 bits: formatted load result, registered.
REQ-010 SHALL have port mem_ready, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port mem_fault, output, 1 bit: misaligned, invalid-format or timeout indication, valid while mem_ready=1.
REQ-012 SHALL have ports bus_req (output, 1), bus_we (output, 1), bus_addr (output, 32), bus_byte_enable (output, 4), bus_wdata (output, 32), bus_rdata (input, 32) and bus_ack (input, 1): word-wide memory bus.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-014 In IDLE with mem_read_enable or mem_write_enable high, SHALL capture address, data_format and write_data at the clock edge and move to DONE on a fault, otherwise to BUSY.
REQ-015 When both enables are high, the write SHALL take priority.
REQ-016 A fault SHALL be raised for: format 001/101 with address[0]=1; format 010 with address[1:0]!=0; format 011, 110 or 111.
REQ-017 In BUSY, SHALL hold bus_req=1 and all bus_* outputs stable until bus_ack is sampled high, then move to DONE.
REQ-018 bus_addr SHALL be {address[31:2],2'b00}.
REQ-019 bus_byte_enable SHALL be: byte -> 4'b0001<<address[1:0]; half -> 4'b0011<<address[1:0]; word -> 4'b1111.
REQ-020 bus_wdata SHALL carry the write byte or half replicated across all lanes (word unchanged).
REQ-021 On an ack for a read, read_data SHALL load the selected lane of bus_rdata, sign-extended for 000/001 and zero-extended for 100/101.
REQ-022 In DONE, SHALL hold mem_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-023 An enable still high in the cycle after mem_ready SHALL start a new transaction.
REQ-024 Latency: a request sampled at edge 0 with bus_ack high in the first BUSY cycle SHALL give mem_ready in cycle 2; each ack wait cycle adds 1; a fault SHALL give mem_ready in cycle 1.
REQ-025 An 8-bit wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-026 When the wait counter reaches TIMEOUT_CYCLES, SHALL drop bus_req and enter DONE with mem_fault=1.
REQ-027 On a fault or timeout, read_data SHALL be 0 and no bus write SHALL occur.
REQ-028 Outside BUSY, bus_req SHALL be 0; bus_we SHALL equal the captured write flag.
REQ-029 bus_ack outside BUSY SHALL be ignored.
REQ-030 mem_fault SHALL be 0 whenever mem_ready=0.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE, bus_req=0, bus_we=0, bus_byte_enable=0, mem_ready=0, mem_fault=0, read_data=0 and wait counter=0.
REQ-032 Reset mid-BUSY SHALL abandon the transaction with no completion pulse; an ack arriving after reset SHALL be ignored.

Verification
REQ-033 LB at address 0x103, bus_rdata=0x80FF_FFFF, ack in first BUSY cycle -> bus_byte_enable=1000, read_data=0xFFFF_FF80, mem_ready in cycle 2.
REQ-034 SH at address 0x202, write_data=0x0000_ABCD, ack after 3 wait cycles -> bus_byte_enable=1100, bus_wdata=0xABCD_ABCD, mem_ready in cycle 5, mem_fault=0.
REQ-035 LW at address 0x101 -> no bus_req, mem_ready with mem_fault=1 in cycle 1, read_data=0.
REQ-036 TIMEOUT_CYCLES=4, LHU with bus_ack held low -> bus_req high for 4 cycles, then mem_ready=1 and mem_fault=1.
REQ-037 Reset pulsed during BUSY, then ack driven -> bus_req=0 at once, no mem_ready; a following LBU at 0x0 with bus_rdata=0x0000_00F0 -> read_data=0x0000_00F0.
REQ-038 Read and write enables both high -> bus_we=1 and a store is performed.
